// File: rtl/print_mech_pkg.sv
// Shared types and constants for the thermal print-mechanism driver.
//   driver_state_e : top-level sequencing states
//   PHASE_SEQ      : stepper phase patterns {a, b, na, nb} indexed by phase index
//   HEAD_WIDTH_DEF : default dots per print line
package print_mech_pkg;

    localparam int HEAD_WIDTH_DEF = 384;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_LATCH,
        ST_BURN,
        ST_STEP
    } driver_state_e;

    localparam logic [3:0] PHASE_SEQ [4] = '{4'b1100, 4'b0110, 4'b0011, 4'b1001};

endpackage

// File: rtl/print_mechanism_driver_stepper.sv
// Stepper motor phase driver. Each step_req advances the phase index by one
// (mod 4), loads the new phase pattern and starts a dwell of STEP_CYCLES.
// step_done is high in the final cycle of the dwell.
//   clk, reset      : system clock, async active-high reset
//   step_req        : pulse, advance one step (takes priority over a running dwell)
//   phase_a/b/na/nb : registered stepper phase outputs
//   step_done       : last dwell cycle of the current step
module stepper_driver
    import print_mech_pkg::*;
#(
    parameter int STEP_CYCLES = 2000
) (
    input  logic clk,
    input  logic reset,
    input  logic step_req,
    output logic phase_a,
    output logic phase_b,
    output logic phase_na,
    output logic phase_nb,
    output logic step_done
);

    localparam int DW = $clog2(STEP_CYCLES + 1);
    localparam logic [DW-1:0] DWELL_LOAD = DW'(STEP_CYCLES - 1);

    logic [1:0]    phase_idx;
    logic [1:0]    phase_idx_next;
    logic [3:0]    pattern;
    logic [DW-1:0] dwell;
    logic          busy;

    assign phase_idx_next = phase_idx + 2'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_idx <= 2'd0;
            pattern   <= PHASE_SEQ[0];
            dwell     <= '0;
            busy      <= 1'b0;
        end else if (step_req) begin
            phase_idx <= phase_idx_next;
            pattern   <= PHASE_SEQ[phase_idx_next];
            dwell     <= DWELL_LOAD;
            busy      <= 1'b1;
        end else if (busy) begin
            if (dwell == '0) begin
                busy <= 1'b0;
            end else begin
                dwell <= dwell - DW'(1);
            end
        end
    end

    assign step_done = busy && (dwell == '0);
    assign {phase_a, phase_b, phase_na, phase_nb} = pattern;

endmodule

// File: rtl/print_mechanism_driver.sv
// Transmit side of the thermal print-mechanism interface. Accepts one line per
// handshake, shifts it out MSB first on mech_clk/mech_data, pulses mech_latch
// low, strobes mech_dst for the burn time, then feeds paper by LINE_STEPS
// motor steps.
//   clk, reset            : system clock, async active-high reset
//   line_valid, line_data : line handshake input (data sampled on acceptance)
//   line_ready            : idle, a line can be accepted
//   line_done             : one-cycle pulse when the paper feed completes
//   mech_clk, mech_data   : head shift clock / serial data
//   mech_latch            : head latch, active low
//   mech_dst              : head strobe, active high
//   motor_phase_*         : stepper phases
module print_mechanism_driver
    import print_mech_pkg::*;
#(
    parameter int HEAD_WIDTH   = HEAD_WIDTH_DEF,
    parameter int CLK_DIV      = 4,
    parameter int LATCH_CYCLES = 4,
    parameter int BURN_CYCLES  = 1000,
    parameter int STEP_CYCLES  = 2000,
    parameter int LINE_STEPS   = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  line_valid,
    input  logic [HEAD_WIDTH-1:0] line_data,
    output logic                  line_ready,
    output logic                  line_done,
    output logic                  mech_clk,
    output logic                  mech_data,
    output logic                  mech_latch,
    output logic                  mech_dst,
    output logic                  motor_phase_a,
    output logic                  motor_phase_b,
    output logic                  motor_phase_na,
    output logic                  motor_phase_nb
);

    localparam int DIVW  = $clog2(CLK_DIV + 1);
    localparam int BITW  = $clog2(HEAD_WIDTH + 1);
    localparam int TMAX  = (LATCH_CYCLES > BURN_CYCLES) ? LATCH_CYCLES : BURN_CYCLES;
    localparam int TMRW  = $clog2(TMAX + 1);
    localparam int STPW  = $clog2(LINE_STEPS + 1);

    localparam logic [DIVW-1:0] DIV_LOAD   = DIVW'(CLK_DIV - 1);
    localparam logic [BITW-1:0] BIT_LAST   = BITW'(HEAD_WIDTH - 1);
    localparam logic [TMRW-1:0] LATCH_LOAD = TMRW'(LATCH_CYCLES - 1);
    localparam logic [TMRW-1:0] BURN_LOAD  = TMRW'(BURN_CYCLES - 1);
    localparam logic [STPW-1:0] STEPS_LAST = STPW'(LINE_STEPS);

    driver_state_e         state, state_next;
    logic [HEAD_WIDTH-1:0] shreg, shreg_next;
    logic [DIVW-1:0]       div_cnt, div_next;
    logic [BITW-1:0]       bit_cnt, bit_next;
    logic [TMRW-1:0]       tmr, tmr_next;
    logic [STPW-1:0]       step_cnt, step_cnt_next;
    logic                  ready_next, done_next;
    logic                  mclk_next, mdata_next, latch_next, dst_next;
    logic                  step_req, step_done;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            shreg      <= '0;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            tmr        <= '0;
            step_cnt   <= '0;
            line_ready <= 1'b1;
            line_done  <= 1'b0;
            mech_clk   <= 1'b0;
            mech_data  <= 1'b0;
            mech_latch <= 1'b1;
            mech_dst   <= 1'b0;
        end else begin
            state      <= state_next;
            shreg      <= shreg_next;
            div_cnt    <= div_next;
            bit_cnt    <= bit_next;
            tmr        <= tmr_next;
            step_cnt   <= step_cnt_next;
            line_ready <= ready_next;
            line_done  <= done_next;
            mech_clk   <= mclk_next;
            mech_data  <= mdata_next;
            mech_latch <= latch_next;
            mech_dst   <= dst_next;
        end
    end

    // Every output is computed one cycle ahead so the registered value lines
    // up with the state it belongs to.
    always_comb begin
        state_next    = state;
        shreg_next    = shreg;
        div_next      = div_cnt;
        bit_next      = bit_cnt;
        tmr_next      = tmr;
        step_cnt_next = step_cnt;
        ready_next    = line_ready;
        done_next     = 1'b0;
        mclk_next     = mech_clk;
        mdata_next    = mech_data;
        latch_next    = mech_latch;
        dst_next      = mech_dst;
        step_req      = 1'b0;

        case (state)
            ST_IDLE: begin
                if (line_valid && line_ready) begin
                    state_next = ST_SHIFT;
                    shreg_next = line_data;
                    div_next   = DIV_LOAD;
                    bit_next   = '0;
                    ready_next = 1'b0;
                    mclk_next  = 1'b0;
                    mdata_next = line_data[HEAD_WIDTH-1];
                end
            end
            ST_SHIFT: begin
                if (div_cnt != '0) begin
                    div_next = div_cnt - DIVW'(1);
                end else if (!mech_clk) begin
                    mclk_next = 1'b1;
                    div_next  = DIV_LOAD;
                end else begin
                    // falling transition: move on to the next bit or finish
                    mclk_next = 1'b0;
                    if (bit_cnt == BIT_LAST) begin
                        mdata_next = 1'b0;
                        latch_next = 1'b0;
                        tmr_next   = LATCH_LOAD;
                        state_next = ST_LATCH;
                    end else begin
                        shreg_next = shreg << 1;
                        mdata_next = shreg_next[HEAD_WIDTH-1];
                        bit_next   = bit_cnt + BITW'(1);
                        div_next   = DIV_LOAD;
                    end
                end
            end
            ST_LATCH: begin
                if (tmr != '0) begin
                    tmr_next = tmr - TMRW'(1);
                end else begin
                    latch_next = 1'b1;
                    dst_next   = 1'b1;
                    tmr_next   = BURN_LOAD;
                    state_next = ST_BURN;
                end
            end
            ST_BURN: begin
                if (tmr != '0) begin
                    tmr_next = tmr - TMRW'(1);
                end else begin
                    // first step starts on the same edge the strobe ends
                    dst_next      = 1'b0;
                    step_req      = 1'b1;
                    step_cnt_next = STPW'(1);
                    state_next    = ST_STEP;
                end
            end
            ST_STEP: begin
                if (step_done) begin
                    if (step_cnt == STEPS_LAST) begin
                        done_next  = 1'b1;
                        ready_next = 1'b1;
                        state_next = ST_IDLE;
                    end else begin
                        step_req      = 1'b1;
                        step_cnt_next = step_cnt + STPW'(1);
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    stepper_driver #(
        .STEP_CYCLES(STEP_CYCLES)
    ) u_stepper (
        .clk       (clk),
        .reset     (reset),
        .step_req  (step_req),
        .phase_a   (motor_phase_a),
        .phase_b   (motor_phase_b),
        .phase_na  (motor_phase_na),
        .phase_nb  (motor_phase_nb),
        .step_done (step_done)
    );

endmodule
